sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO for buffering ICB-side command/data beats ahead of the APB state machine when both sides share one clock domain. Arbitrary (not only power-of-two) depth, an exact occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags. Compile-time selectable read mode: registered read or first-word-fall-through.

## Interface
Parameters:
- `DATA_WIDTH`, 64, width of each stored word (≥1).
- `DEPTH`, 16, number of entries (≥2, any integer).
- `ADDR_SIZE`, `$clog2(DEPTH)`, pointer width (derived; not overridden).
- `LVL_SIZE`, `$clog2(DEPTH+1)`, width of occupancy count (derived).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `wen`  in  1  write request.
- `data_w`  in  DATA_WIDTH  write data.
- `ren`  in  1  read request (pop).
- `data_r`  out  DATA_WIDTH  read data.
- `flush`  in  1  synchronous clear of contents.
- `af_thresh`  in  LVL_SIZE  almost-full threshold.
- `ae_thresh`  in  LVL_SIZE  almost-empty threshold.
- `err_clr`  in  1  clears sticky error flags.
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `almost_full`  out  1  level >= af_thresh.
- `almost_empty`  out  1  level <= ae_thresh.
- `level`  out  LVL_SIZE  current occupancy.
- `overflow`  out  1  sticky: write attempted while full.
- `underflow`  out  1  sticky: read attempted while empty.

## Operation
- Write accepted iff `wen && !full`: `data_w` stored at `wr_ptr`, `wr_ptr` advances.
- Read accepted iff `ren && !empty`: `rd_ptr` advances.
- Pointers are `ADDR_SIZE` bits, wrap explicitly from DEPTH-1 to 0 (no reliance on natural overflow; non-power-of-two DEPTH must work).
- `level` register: +1 on write-only, −1 on read-only, unchanged on both or neither.
- Simultaneous accepted read and write: both happen, level unchanged. When full, `wen` is rejected even if `ren` is accepted the same cycle; when empty, `ren` is rejected even if `wen` is accepted.
- `full`, `empty`, `almost_full`, `almost_empty` are combinational from the `level` register and thresholds; thresholds may change at any time.
- `overflow` set on `wen && full`; `underflow` set on `ren && empty`. Both stay set until `err_clr`. If set and clear coincide, set wins.
- `flush` (priority over `wen`/`ren`): pointers and level go to 0 next cycle; `wen`/`ren` in that cycle ignored and do not set error flags; memory and `data_r` register untouched; error flags untouched.
- Storage array is not reset; no output depends on unwritten entries while `empty`.

## Timing
- Reset values: `data_r`=0, `level`=0, `full`=0, `empty`=1, `overflow`=0, `underflow`=0; `almost_full`/`almost_empty` follow thresholds against level 0.
- Flags and `level` update on the edge after the accepted operation.
- Registered mode: `data_r` loads the head word on the edge of an accepted read (1-cycle latency) and holds otherwise.
- Write-to-read: a word written at edge N is readable (`empty`=0) after edge N; first read accepted at edge N+1 at earliest.
- Reset asserted mid-operation: all state returns to reset values immediately; contents are discarded.

## Configuration
- `SYNC_FIFO_FWFT_EN` defined: first-word-fall-through; `data_r` is the head entry `mem[rd_ptr]` combinationally, valid whenever `empty`=0; `ren` pops with no latency; `data_r` has no register and no reset value (don't-care while empty).
- Undefined: registered read mode as in Timing.

## Test plan
- Reset, write 0x11,0x22,0x33 → `level`=3, `empty`=0; three reads → `data_r` 0x11,0x22,0x33 in order (1 cycle after each `ren`, or immediately in FWFT), `empty`=1.
- DEPTH=5: 5 writes → `full`=1; 6th write → dropped, `overflow`=1; `err_clr` → 0; read/write 12 more words → correct order across wrap.
- At `full`, `wen`+`ren` together → read taken, write rejected, `level`=4 (DEPTH=5), `overflow`=1.
- Empty: `ren` → `underflow`=1, `level` stays 0; `wen`+`ren` → write only, `level`=1.
- `af_thresh`=3, `ae_thresh`=1: levels 0..4 → `almost_empty` 1,1,0,0,0; `almost_full` 0,0,0,1,1.
- Level 4 then `flush` with `wen`=1 → next cycle `level`=0, `empty`=1, no error flags; next write/read returns new data.

Source files
------------

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with arbitrary depth, level count, thresholds, flush and sticky errors
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; otherwise data_r is registered.
module sync_fifo #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 16,
   parameter int ADDR_SIZE  = $clog2(DEPTH),
   parameter int LVL_SIZE   = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wen,
   input  logic [DATA_WIDTH-1:0] data_w,
   input  logic                  ren,
   output logic [DATA_WIDTH-1:0] data_r,
   input  logic                  flush,
   input  logic [LVL_SIZE-1:0]   af_thresh,
   input  logic [LVL_SIZE-1:0]   ae_thresh,
   input  logic                  err_clr,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [LVL_SIZE-1:0]   level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_SIZE-1:0] LAST_PTR  = ADDR_SIZE'(DEPTH - 1);
   localparam logic [LVL_SIZE-1:0]  DEPTH_LVL = LVL_SIZE'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_SIZE-1:0]   level_q, level_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_acc, rd_acc;

   assign full         = (level_q == DEPTH_LVL);
   assign empty        = (level_q == '0);
   assign almost_full  = (level_q >= af_thresh);
   assign almost_empty = (level_q <= ae_thresh);
   assign level        = level_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // Flush swallows the same-cycle requests entirely, including their error side effects.
   assign wr_acc = wen && !full && !flush;
   assign rd_acc = ren && !empty && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ADDR_SIZE'(1);
         end
         if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ADDR_SIZE'(1);
         end
         if (wr_acc && !rd_acc) begin
            level_d = level_q + LVL_SIZE'(1);
         end else if (rd_acc && !wr_acc) begin
            level_d = level_q - LVL_SIZE'(1);
         end
      end
      overflow_d  = (wen && full && !flush) || (overflow_q && !err_clr);
      underflow_d = (ren && empty && !flush) || (underflow_q && !err_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= data_w;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign data_r = mem_q[rd_ptr_q];
`else
   logic [DATA_WIDTH-1:0] data_r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r_q <= '0;
      end else if (rd_acc) begin
         data_r_q <= mem_q[rd_ptr_q];
      end
   end

   assign data_r = data_r_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo at DEPTH=5, 8-bit data
// Follows SYNC_FIFO_FWFT_EN to pick where read data is expected.
module tb_sync_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 5;
   localparam int LW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wen, ren, flush, err_clr;
   logic [DW-1:0] data_w, data_r;
   logic [LW-1:0] af_thresh, ae_thresh, level;
   logic          full, empty, almost_full, almost_empty, overflow, underflow;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] sb_q [$];
   logic          m_ovf, m_udf;

   sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .wen(wen), .data_w(data_w), .ren(ren), .data_r(data_r),
      .flush(flush), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
      .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .level(level), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // One clock of stimulus; scoreboard tracks accepted beats and sticky errors.
   task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
      logic          exp_w, exp_r;
      logic [DW-1:0] exp_d;
      exp_w = w && !f && (sb_q.size() < DEPTH);
      exp_r = r && !f && (sb_q.size() > 0);
      exp_d = '0;
      if (exp_r) exp_d = sb_q[0];
      m_ovf = (w && !f && sb_q.size() == DEPTH) || (m_ovf && !err_clr);
      m_udf = (r && !f && sb_q.size() == 0) || (m_udf && !err_clr);
      wen = w; data_w = d; ren = r; flush = f;
`ifdef SYNC_FIFO_FWFT_EN
      if (exp_r) begin
         n_checks++;
         if (data_r !== exp_d) begin
            n_fail++;
            $display("FAIL read_data: got %h expected %h", data_r, exp_d);
         end
      end
`endif
      @(posedge clk); #1;
      if (exp_r) void'(sb_q.pop_front());
      if (exp_w) sb_q.push_back(d);
      if (f) sb_q.delete();
`ifndef SYNC_FIFO_FWFT_EN
      if (exp_r) begin
         n_checks++;
         if (data_r !== exp_d) begin
            n_fail++;
            $display("FAIL read_data: got %h expected %h", data_r, exp_d);
         end
      end
`endif
      n_checks++;
      if (level !== LW'(sb_q.size())) begin
         n_fail++;
         $display("FAIL level: got %0d expected %0d", level, sb_q.size());
      end
      n_checks++;
      if (overflow !== m_ovf || underflow !== m_udf) begin
         n_fail++;
         $display("FAIL err_flags: got ovf=%b udf=%b expected ovf=%b udf=%b",
                  overflow, underflow, m_ovf, m_udf);
      end
      wen = 1'b0; ren = 1'b0; flush = 1'b0; err_clr = 1'b0;
   endtask

   task automatic clear_errors();
      err_clr = 1'b1;
      cycle(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1 && sb_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wen = 0; ren = 0; flush = 0; err_clr = 0; data_w = '0;
      af_thresh = 3'd3; ae_thresh = 3'd1;
      sb_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (level !== '0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got lvl=%0d e=%b f=%b o=%b u=%b expected 0 1 0 0 0",
                  level, empty, full, overflow, underflow);
      end
      n_checks++;
      if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_thresh: got af=%b ae=%b expected af=0 ae=1", almost_full, almost_empty);
      end
`ifndef SYNC_FIFO_FWFT_EN
      n_checks++;
      if (data_r !== '0) begin
         n_fail++;
         $display("FAIL reset_data_r: got %h expected 00", data_r);
      end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      cycle(1'b1, 8'h11, 1'b0, 1'b0);
      cycle(1'b1, 8'h22, 1'b0, 1'b0);
      cycle(1'b1, 8'h33, 1'b0, 1'b0);
      n_checks++;
      if (level !== 3'd3 || empty !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_fill: got lvl=%0d e=%b expected 3 0", level, empty);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      cycle(1'b0, '0, 1'b0, 1'b0);
      n_checks++;
      if (data_r !== 8'h11) begin
         n_fail++;
         $display("FAIL basic_hold: got %h expected 11", data_r);
      end
`endif
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (empty !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_empty: got %b expected 1", empty);
      end
   endtask

   task automatic test_full_wrap();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
      n_checks++;
      if (full !== 1'b1) begin
         n_fail++;
         $display("FAIL full_set: got %b expected 1", full);
      end
      cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      n_checks++;
      if (overflow !== 1'b1 || level !== 3'd5) begin
         n_fail++;
         $display("FAIL overflow_drop: got ovf=%b lvl=%0d expected 1 5", overflow, level);
      end
      clear_errors();
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clr: got %b expected 0", overflow);
      end
      drain();
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, DW'($urandom_range(0, 255)), (i % 3) != 0, 1'b0);
      end
      drain();
   endtask

   task automatic test_full_both();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
      cycle(1'b1, 8'hDD, 1'b1, 1'b0);
      n_checks++;
      if (level !== 3'd4 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL full_both: got lvl=%0d ovf=%b expected 4 1", level, overflow);
      end
      drain();
      clear_errors();
   endtask

   task automatic test_empty();
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (underflow !== 1'b1 || level !== '0) begin
         n_fail++;
         $display("FAIL underflow: got udf=%b lvl=%0d expected 1 0", underflow, level);
      end
      cycle(1'b1, 8'h77, 1'b1, 1'b0);
      n_checks++;
      if (level !== 3'd1) begin
         n_fail++;
         $display("FAIL empty_both: got lvl=%0d expected 1", level);
      end
      drain();
      clear_errors();
   endtask

   task automatic test_thresholds();
      logic [4:0] exp_ae, exp_af;
      exp_ae = 5'b00011;
      exp_af = 5'b11000;
      af_thresh = 3'd3; ae_thresh = 3'd1;
      for (int l = 0; l < 5; l++) begin
         #1;
         n_checks++;
         if (almost_empty !== exp_ae[l] || almost_full !== exp_af[l]) begin
            n_fail++;
            $display("FAIL thresh_lvl%0d: got ae=%b af=%b expected ae=%b af=%b",
                     l, almost_empty, almost_full, exp_ae[l], exp_af[l]);
         end
         cycle(1'b1, DW'(8'h80 + l), 1'b0, 1'b0);
      end
      drain();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'h90 + i), 1'b0, 1'b0);
      cycle(1'b1, 8'hBB, 1'b0, 1'b1);
      n_checks++;
      if (level !== '0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL flush: got lvl=%0d e=%b o=%b u=%b expected 0 1 0 0",
                  level, empty, overflow, underflow);
      end
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 8'hC1, 1'b0, 1'b0);
      cycle(1'b1, 8'hC2, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (level !== '0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid: got lvl=%0d e=%b expected 0 1", level, empty);
      end
      sb_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle(1'b1, 8'hD7, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_wrap();
      test_full_both();
      test_empty();
      test_thresholds();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
